// File: rtl/vga_lane_display_if.sv
// vga_lane_display_if: game-logic inputs, background fetch path and video outputs of vga_lane_display
//   lane_level  2*NUM_LANES  lane k level in [2k+1:2k], 0 = off
//   mistake     32           mistake counter from game logic
//   bg_bgr      24           background {b,g,r}, valid BG_LAT clocks after addr
//   addr        19           background pixel address
//   hs/vs       1            active-low syncs
//   blank_n     1            high during active video
//   frame_done  1            one-clock pulse at start of vertical front porch
//   b/g/r_data  8            colour channels
interface vga_lane_display_if #(
   parameter int NUM_LANES = 4
);
   logic [2*NUM_LANES-1:0] lane_level;
   logic [31:0] mistake;
   logic [23:0] bg_bgr;
   logic [18:0] addr;
   logic hs, vs, blank_n, frame_done;
   logic [7:0] b_data, g_data, r_data;
   modport master (
      input  lane_level, mistake, bg_bgr,
      output addr, hs, vs, blank_n, frame_done, b_data, g_data, r_data
   );
   modport slave (
      output lane_level, mistake, bg_bgr,
      input  addr, hs, vs, blank_n, frame_done, b_data, g_data, r_data
   );
endinterface

// File: rtl/vga_lane_display.sv
// vga_lane_display: VGA timing, background address generation and lane overlay compositing
//   iVGA_CLK  pixel clock
//   iRST      synchronous active-high reset
//   bus       vga_lane_display_if.master (lane levels/mistake in, background fetch, sync/blank/colour out)
//   MISTAKE_FLASH_EN: when defined, a red screen border is shown for 8 frames after iMISTAKE changes
module vga_lane_display #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP = 33,
   parameter int NUM_LANES = 4,
   parameter int LANE_X0 = 154,
   parameter int LANE_PITCH = 100,
   parameter int LANE_W = 38,
   parameter int LANE_Y0 = 199,
   parameter int LANE_H = 48,
   parameter int BG_LAT = 2,
   parameter logic [23:0] COL_L1 = 24'h90EE90,
   parameter logic [23:0] COL_L2 = 24'h32CD32,
   parameter logic [23:0] COL_L3 = 24'h006400
) (
   input logic iVGA_CLK,
   input logic iRST,
   vga_lane_display_if.master bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int P = BG_LAT + 1;
   localparam logic [HW-1:0] H_A = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_L = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_A = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_L = VW'(V_TOTAL - 1);
   localparam logic [18:0] PIX_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

   logic [HW-1:0] hc;
   logic [VW-1:0] vc;
   logic [18:0] pix;
   logic act0, hs0, vs0, latch0;
   logic [2*NUM_LANES-1:0] frame_lvl;
   logic act_p [P];
   logic hs_p [P];
   logic vs_p [P];
   logic [HW-1:0] x_p [P];
   logic [VW-1:0] y_p [P];
   logic [31:0] xf, yf;
   logic [1:0] lv;
   logic lane_hit, border;
   logic [23:0] lane_col, pix_col;

   assign act0 = hc < H_A && vc < V_A;
   assign hs0 = !(hc >= H_SS && hc < H_SE);
   assign vs0 = !(vc >= V_SS && vc < V_SE);
   assign latch0 = hc == '0 && vc == V_A;

   always_ff @(posedge iVGA_CLK)
      if (iRST) begin
         hc <= '0;
         vc <= '0;
      end else begin
         hc <= hc == H_L ? '0 : hc + 1'b1;
         if (hc == H_L) vc <= vc == V_L ? '0 : vc + 1'b1;
      end

   // pix counts active pixels already scanned this frame; it wraps exactly
   // at the last visible pixel, so it sits at 0 through vertical blanking.
   always_ff @(posedge iVGA_CLK)
      if (iRST) begin
         pix <= '0;
         bus.addr <= '0;
         bus.frame_done <= 1'b0;
         frame_lvl <= '0;
      end else begin
         if (act0) pix <= pix == PIX_LAST ? '0 : pix + 1'b1;
         bus.addr <= pix;
         bus.frame_done <= latch0;
         if (latch0) frame_lvl <= bus.lane_level;
      end

   assign xf = 32'(x_p[P-1]);
   assign yf = 32'(y_p[P-1]);

`ifdef MISTAKE_FLASH_EN
   logic [31:0] prev_mistake;
   logic [3:0] flash;

   always_ff @(posedge iVGA_CLK)
      if (iRST) begin
         prev_mistake <= '0;
         flash <= '0;
      end else if (latch0) begin
         prev_mistake <= bus.mistake;
         flash <= bus.mistake != prev_mistake ? 4'd8 : flash != '0 ? flash - 1'b1 : flash;
      end

   assign border = flash != '0 && (xf < 4 || xf >= 32'(H_ACTIVE - 4) || yf < 4 || yf >= 32'(V_ACTIVE - 4));
`else
   logic unused_mistake;
   assign unused_mistake = ^bus.mistake;
   assign border = 1'b0;
`endif

   // Scan from the highest lane down so the lowest-numbered hit overwrites the rest.
   always_comb begin
      lv = '0;
      lane_hit = 1'b0;
      lane_col = '0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         lv = frame_lvl[2*k +: 2];
         if (lv != 2'd0 && xf >= 32'(LANE_X0 + k*LANE_PITCH) && xf < 32'(LANE_X0 + k*LANE_PITCH + LANE_W) &&
             yf >= 32'(LANE_Y0) && yf < 32'(LANE_Y0 + LANE_H)) begin
            lane_hit = 1'b1;
            lane_col = lv == 2'd1 ? COL_L1 : lv == 2'd2 ? COL_L2 : COL_L3;
         end
      end
   end

   assign pix_col = !act_p[P-1] ? 24'h0 : border ? 24'h0000FF : lane_hit ? lane_col : bus.bg_bgr;

   // Timing travels alongside the background fetch so syncs, blank and colour leave together.
   always_ff @(posedge iVGA_CLK)
      if (iRST) begin
         for (int i = 0; i < P; i++) begin
            act_p[i] <= 1'b0;
            hs_p[i] <= 1'b1;
            vs_p[i] <= 1'b1;
            x_p[i] <= '0;
            y_p[i] <= '0;
         end
         bus.hs <= 1'b1;
         bus.vs <= 1'b1;
         bus.blank_n <= 1'b0;
         {bus.b_data, bus.g_data, bus.r_data} <= '0;
      end else begin
         act_p[0] <= act0;
         hs_p[0] <= hs0;
         vs_p[0] <= vs0;
         x_p[0] <= hc;
         y_p[0] <= vc;
         for (int i = 1; i < P; i++) begin
            act_p[i] <= act_p[i-1];
            hs_p[i] <= hs_p[i-1];
            vs_p[i] <= vs_p[i-1];
            x_p[i] <= x_p[i-1];
            y_p[i] <= y_p[i-1];
         end
         bus.hs <= hs_p[P-1];
         bus.vs <= vs_p[P-1];
         bus.blank_n <= act_p[P-1];
         {bus.b_data, bus.g_data, bus.r_data} <= pix_col;
      end
endmodule
